// File: rtl/mbe_pkg.sv
// Shared widths and types for the MBE radix-8 3X multiple generator and its scheduler.
package mbe_pkg;

  localparam int MW = 23;
  localparam int PW = MW + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} tg_state_e;

  typedef logic [MW-1:0] mant_t;
  typedef logic [PW-1:0] trip_t;

endpackage

// File: rtl/rca_adder.sv
// Plain ripple-carry adder; the carry chain is long, so users hold its inputs
// stable for a multicycle settle window before sampling the sum.
module rca_adder #(
  parameter int N = 25
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  logic [N-1:0] carry;

  assign carry[0] = cin;

  // The carry out of the top bit is never needed by the callers, so it is not built.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from the one after the previous winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/triple_gen_sched.sv
// Time-shares one ripple-carry adder among NREQ requesters to form 3X = X + 2X,
// allowing SETTLE cycles for the carry chain before capturing the result.
module triple_gen_sched
  import mbe_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int MW     = 23,
  parameter  int SETTLE = 2,
  localparam int IW     = $clog2(NREQ),
  localparam int RW     = MW + 2,
  localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*MW-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [RW-1:0]      rsp_3x,
  output logic               busy
);

  tg_state_e     state, state_next;
  logic [CW-1:0] cnt;
  logic [RW-1:0] op_a, op_b, sum;
  logic [IW-1:0] last, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [MW-1:0] x_sel;

  // Gating with rst_n keeps req_ready low while reset is held, not just after it.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last),
    .en      ((state == IDLE) && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  rca_adder #(.N(RW)) u_add (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (sum)
  );

  assign req_ready = gnt;
  assign rsp_valid = (state == RESP);

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) x_sel = req_x[i*MW +: MW];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|gnt) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Operands stay frozen through WAIT so the adder path only has to settle once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      rsp_id <= '0;
      rsp_3x <= '0;
      last   <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            op_a   <= {2'b00, x_sel};
            op_b   <= {1'b0, x_sel, 1'b0};
            rsp_id <= gnt_idx;
            last   <= gnt_idx;
            cnt    <= CW'(SETTLE - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) rsp_3x <= sum;
          else           cnt    <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triple_gen_sched.sv
// Randomized scoreboard bench for triple_gen_sched against a cycle-level
// round-robin reference model; extra instances cover other settle windows.
module tb_triple_gen_sched;

  localparam int NREQ   = 4;
  localparam int MW     = 23;
  localparam int SETTLE = 2;
  localparam int RW     = MW + 2;
  localparam int IW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*MW-1:0] req_x;
  logic               rsp_valid, rsp_ready, busy;
  logic [IW-1:0]      rsp_id;
  logic [RW-1:0]      rsp_3x;

  logic [NREQ-1:0]    sv_valid [2];
  logic [NREQ*MW-1:0] sv_x     [2];
  logic               sv_rdy   [2];
  logic [NREQ-1:0]    so_ready [2];
  logic               so_valid [2];
  logic [IW-1:0]      so_id    [2];
  logic [RW-1:0]      so_3x    [2];
  logic               so_busy  [2];

  triple_gen_sched #(.NREQ(NREQ), .MW(MW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_3x(rsp_3x), .busy(busy)
  );

  triple_gen_sched #(.NREQ(NREQ), .MW(MW), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .req_valid(sv_valid[0]), .req_x(sv_x[0]),
    .req_ready(so_ready[0]), .rsp_valid(so_valid[0]), .rsp_ready(sv_rdy[0]),
    .rsp_id(so_id[0]), .rsp_3x(so_3x[0]), .busy(so_busy[0])
  );

  triple_gen_sched #(.NREQ(NREQ), .MW(MW), .SETTLE(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .req_valid(sv_valid[1]), .req_x(sv_x[1]),
    .req_ready(so_ready[1]), .rsp_valid(so_valid[1]), .rsp_ready(sv_rdy[1]),
    .rsp_id(so_id[1]), .rsp_3x(so_3x[1]), .busy(so_busy[1])
  );

  typedef struct {
    int     id;
    longint val;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   cur_exp;
  int     grant_log[$];
  int     acc_log[$];
  int     checks = 0;
  int     errors = 0;
  int     viol   = 0;
  int     cyc    = 0;
  bit     inflight = 1'b0;
  int     model_last = NREQ - 1;
  int     done_cyc = 0;
  bit     popped = 1'b0;
  longint last_seen_3x = 0;
  int     last_seen_id = 0;
  logic [NREQ-1:0] granted = '0;
  logic [NREQ-1:0] pend_valid = '0;
  logic [MW-1:0]   pend_x [NREQ];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (((v >> ((last + k) % NREQ)) & 1'b1) != 0) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [MW-1:0] randMant();
    case ($urandom_range(3))
      0:       return '0;
      1:       return '1;
      default: return MW'($urandom);
    endcase
  endfunction

  // Reference model: who should be granted, when results appear, and what they hold.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ*MW-1:0] sh;
    bit exp_rv;
    cyc++;
    if (!rst_n) begin
      inflight   = 1'b0;
      model_last = NREQ - 1;
      exp_q.delete();
    end else begin
      g       = inflight ? -1 : rrPick(req_valid, model_last);
      exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
      exp_rv  = inflight && (cyc >= done_cyc);
      checkOutput("req_ready", longint'(req_ready), longint'(exp_rdy));
      checkOutput("busy", longint'(busy), longint'(inflight));
      checkOutput("rsp_valid", longint'(rsp_valid), longint'(exp_rv));
      if (exp_rv && rsp_ready) begin
        inflight = 1'b0;
      end else if (g >= 0) begin
        sh = req_x >> (g * MW);
        exp_q.push_back('{g, longint'(sh[MW-1:0]) * 3});
        grant_log.push_back(g);
        acc_log.push_back(cyc);
        inflight   = 1'b1;
        model_last = g;
        done_cyc   = cyc + SETTLE + 1;
      end
    end
  end

  // Monitor: pops an expectation whenever a new response is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      popped = 1'b0;
    end else if (rsp_valid) begin
      if (!popped) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected: got id %0d 3x %0h, required no response", rsp_id, rsp_3x);
          cur_exp = '{int'(rsp_id), longint'(rsp_3x)};
        end else begin
          cur_exp = exp_q.pop_front();
          checkOutput("rsp_id", longint'(rsp_id), longint'(cur_exp.id));
          checkOutput("rsp_3x", longint'(rsp_3x), cur_exp.val);
        end
        popped       = 1'b1;
        last_seen_3x = longint'(rsp_3x);
        last_seen_id = int'(rsp_id);
      end else begin
        checkOutput("rsp_id_stable", longint'(rsp_id), longint'(cur_exp.id));
        checkOutput("rsp_3x_stable", longint'(rsp_3x), cur_exp.val);
      end
      if (rsp_ready) popped = 1'b0;
    end
  end

  // Requester protocol watch: a pending request must hold valid and data until granted.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_valid = '0;
      granted    = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_valid[i] && (!req_valid[i] || req_x[i*MW +: MW] != pend_x[i])) begin
          viol++;
          $display("[TB] protocol violation: requester %0d dropped its request before req_ready", i);
        end
        pend_valid[i] = req_valid[i] && !req_ready[i];
        pend_x[i]     = req_x[i*MW +: MW];
      end
      granted = req_ready & req_valid;
    end
  end

  task automatic applyStimulus(input int req_prob, input int rdy_prob);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (granted[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && int'($urandom_range(99)) < req_prob) begin
        req_valid[i]       = 1'b1;
        req_x[i*MW +: MW]  = randMant();
      end
    end
    rsp_ready = (int'($urandom_range(99)) < rdy_prob);
  endtask

  task automatic setReq(input int i, input logic [MW-1:0] x);
    req_valid[i]      = 1'b1;
    req_x[i*MW +: MW] = x;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((inflight || req_valid != '0) && n < budget) begin
      applyStimulus(0, 100);
      n++;
    end
    if (inflight || req_valid != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic checkLatency(input int w, input int settle, input logic [MW-1:0] x);
    int acc = -1;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    sv_x[w]          = '0;
    sv_x[w][MW-1:0]  = x;
    sv_valid[w]      = 4'b0001;
    sv_rdy[w]        = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (acc < 0) begin
        if (so_ready[w][0]) acc = n;
      end else if (so_valid[w]) begin
        got = 1'b1;
        checkOutput($sformatf("latency_s%0d", settle), longint'(n - acc), longint'(settle + 1));
        checkOutput($sformatf("lat_3x_s%0d", settle), longint'(so_3x[w]), longint'(x) * 3);
        checkOutput($sformatf("lat_id_s%0d", settle), longint'(so_id[w]), 0);
      end
      @(posedge clk);
      #1;
      if (acc >= 0) sv_valid[w] = '0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL latency_timeout_s%0d: no response, required one", settle);
    end
    sv_valid[w] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [MW-1:0] edge_x [3];
    longint        edge_e [3];
    int            n;
    edge_x = '{23'h000000, 23'h000001, 23'h400000};
    edge_e = '{0, 3, 64'hC00000};

    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    rsp_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      sv_valid[w] = '0;
      sv_x[w]     = '0;
      sv_rdy[w]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", longint'(req_ready), 0);
    checkOutput("reset_rsp_valid", longint'(rsp_valid), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] single request, all-ones mantissa");
    applyStimulus(0, 100);
    setReq(1, 23'h7FFFFF);
    waitDrain(50);
    checkOutput("single_3x", last_seen_3x, 64'h17FFFFD);
    checkOutput("single_id", longint'(last_seen_id), 1);

    $display("[TB] edge values");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 100);
      setReq(0, edge_x[k]);
      waitDrain(50);
      checkOutput("edge_3x", last_seen_3x, edge_e[k]);
    end

    $display("[TB] reset during WAIT");
    applyStimulus(0, 100);
    setReq(2, 23'h001234);
    applyStimulus(0, 100);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("rst_req_ready", longint'(req_ready), 0);
    checkOutput("rst_rsp_valid", longint'(rsp_valid), 0);
    checkOutput("rst_rsp_id", longint'(rsp_id), 0);
    checkOutput("rst_rsp_3x", longint'(rsp_3x), 0);
    checkOutput("rst_busy", longint'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] round-robin, all requesters continuous");
    applyStimulus(0, 100);
    grant_log.delete();
    acc_log.delete();
    for (int i = 0; i < NREQ; i++) setReq(i, randMant());
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin
      applyStimulus(100, 100);
      n++;
    end
    if (grant_log.size() < 5) begin
      checks++;
      errors++;
      $display("[TB] FAIL rr_timeout: got %0d grants, required 5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) checkOutput("rr_order", longint'(grant_log[k]), longint'(k % NREQ));
      for (int k = 0; k < 4; k++) checkOutput("rr_period", longint'(acc_log[k+1] - acc_log[k]), SETTLE + 2);
    end
    waitDrain(80);

    $display("[TB] backpressure with early request drop");
    applyStimulus(0, 0);
    setReq(2, 23'd5);
    n = 0;
    while (!(inflight && cyc >= done_cyc) && n < 20) begin
      applyStimulus(0, 0);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL bp_timeout: response not expected yet, required within 20 cycles");
    end
    setReq(0, 23'h0ABCDE);
    setReq(3, 23'h012345);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0);
      if (k == 5) req_valid[3] = 1'b0;
    end
    checkOutput("bp_3x", last_seen_3x, 15);
    checkOutput("bp_id", longint'(last_seen_id), 2);
    waitDrain(60);

    $display("[TB] randomized traffic");
    repeat (600) applyStimulus(35, 70);
    waitDrain(200);

    $display("[TB] alternate settle windows");
    checkLatency(0, 1, randMant());
    checkLatency(0, 1, 23'h7FFFFF);
    checkLatency(1, 4, randMant());
    checkLatency(1, 4, 23'h400000);

    checkOutput("protocol_violations", longint'(viol), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triple_gen_sched.md
# triple_gen_sched

Round-robin scheduler that time-shares one 25-bit ripple-carry adder among several requesters that each need the 3X multiple of a 23-bit mantissa for the MBE radix-8 partial-product generator. For each request it loads A = X and B = 2X into registered adder operands, holds them stable for a programmable multicycle settle window, captures the sum as 3X, and returns it with the requester's id over a valid/ready response channel.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `MW`, 23: mantissa width; result width is MW+2.
- `SETTLE`, 2: number of cycles allowed for the ripple-carry path to settle (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester request.
- `req_x` in NREQ*MW: packed mantissas; requester i occupies bits [i*MW +: MW].
- `req_ready` out NREQ: one-hot accept; at most one bit high.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out $clog2(NREQ): index of the requester that owns the result.
- `rsp_3x` out MW+2: 3·X.
- `busy` out 1: high whenever the FSM state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, the arbiter grants requester g, the first set bit searching from `last+1` (mod NREQ) upward.
  - `req_ready[g]` is high combinationally in that cycle.
  - At the clock edge: `opA <= {2'b0, X}`, `opB <= {1'b0, X, 1'b0}`, `rsp_id <= g`, `last <= g`, `cnt <= SETTLE-1`, state → WAIT.
- **WAIT:**
  - `opA` and `opB` hold constant. The adder path is a declared multicycle path of SETTLE cycles.
  - Each edge decrements `cnt`.
  - At the edge where `cnt == 0`: `rsp_3x <= Sum[MW+1:0]`, state → RESP.
- **RESP:**
  - `rsp_valid` is high. `rsp_3x` and `rsp_id` are stable until the handshake.
  - On the edge where `rsp_valid && rsp_ready`: state → IDLE.
- **Arithmetic:**
  - The adder runs at N = MW+2 with Cin = 0.
  - The maximum result is 3·(2^MW − 1) < 2^(MW+2), so no overflow is possible and the adder carry-out is unused.
- **Requester rules:**
  - A requester holds `req_valid` and `req_x` until it sees `req_ready`. Dropping either before then is a protocol error, checked by a bench assertion.
  - Outside IDLE, all `req_ready` bits are 0.
- **Fairness:**
  - `last` resets to NREQ−1, so requester 0 has first priority after reset.
  - Any continuously requesting source is served within NREQ transactions.
- **Reset:**
  - Asserting `rst_n` low at any time forces IDLE and discards any in-flight operand or result.
  - Outputs are 0 while in reset: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_3x`, `busy`.
  - Internal `cnt`, `opA`, `opB` reset to 0.

## Timing
- **Latency:** accept edge E0; `rsp_valid` rises after edge E0+SETTLE. With SETTLE=2, that is two edges after accept.
- **Throughput:** with `rsp_ready` tied high, one result per SETTLE+2 cycles. There is no accept on the same edge as a response handshake; the earliest next accept is the following edge.
- **Stalls:** `rsp_ready` low stalls indefinitely in RESP. Requesters see `req_ready` low for the whole stall.
- **Request arriving in WAIT or RESP:** not granted until IDLE. Arbitration uses the `req_valid` values present in the IDLE cycle.
- **`busy`:** registered, equal to (state != IDLE).

## Structure
- **Package `mbe_pkg`:**
  - `MW` default and `PW = MW+2`.
  - Typedef `tg_state_e` = {IDLE, WAIT, RESP}.
  - Typedef `mant_t` = logic [MW-1:0] and `trip_t` = logic [PW-1:0].
- **Sub-module `rr_arbiter`** (parameter NREQ): inputs `req`, `last`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`; purely combinational.
- **Top level:** contains the FSM, counter, operand and result registers, and one instance of the team's ripple-carry adder with N = MW+2.

## Test plan
- **Reset:** assert `rst_n` low mid-WAIT → all outputs 0 immediately. After release, requester 0 wins a 4-way simultaneous request.
- **Single request:** `req_x[1] = 23'h7FFFFF`, SETTLE=2 → `rsp_valid` after E0+2 edges, `rsp_3x = 25'h17FFFFD`, `rsp_id = 1`.
- **Round-robin:** all four requesters valid continuously, `rsp_ready` = 1 → grant order 0,1,2,3,0, one result every 4 cycles.
- **Backpressure:** X = 5, `rsp_ready` low for 10 cycles → `rsp_3x = 15` held stable, `busy` = 1, no `req_ready` pulses. Release → IDLE on the next edge.
- **Edge values:** X = 0 → 0; X = 1 → 3; X = 23'h400000 → 25'hC00000. Also run SETTLE=1 and SETTLE=4 and check latency equals SETTLE edges.
- **Protocol assertion:** a requester drops `req_valid` before `req_ready` → the bench assertion fires. The DUT issues no grant to that requester.
